ds1302_write_seq: RTL
=====================

Name: ds1302_write_seq

Overview:
Upstream sequencer for the ds1302write engine. On one `start` request it programs the DS1302 clock with five writes:
- WP unlock
- seconds
- minutes
- hours
- WP lock

For each write it drives the engine's en/addr/dataIn, generates the engine's SCLK input, and waits for the engine's done. It reports completion, an input-validation error or a per-write timeout to the top-level clock-setting logic.

Parameters:
SCLK_HALF, 50, clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz clk); minimum 1
SETUP_CYC, 400, clk cycles with SCLK held low between issuing a write and the first SCLK rise (CE setup)
GAP_CYC, 400, clk cycles with SCLK low after a write's done before the next write is issued (CE inactive time)
TIMEOUT_EDGES, 40, SCLK rising edges allowed per write before declaring timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
secIn  in  8  BCD seconds 00-59
minIn  in  8  BCD minutes 00-59
hourIn  in  8  BCD hours 00-23, 24h mode
busy  out  1  high from accepted start until return to IDLE
done  out  1  one-cycle pulse, all five writes completed
err  out  1  one-cycle pulse, invalid input or timeout
errCode  out  2  valid with err: 01 bad BCD, 10 timeout; holds until next err
stepIdx  out  3  current write index 0-4; 0 in IDLE
wrEn  out  1  one-cycle pulse to ds1302write en
wrAddr  out  8  to ds1302write addr
wrData  out  8  to ds1302write dataIn
sclk  out  1  to ds1302write sclk
wrDone  in  1  ds1302write done (level, sampled)

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, counters cleared. Reset mid-write forces sclk low at once; no done or err is produced.
- FSM states: IDLE, CHECK, ISSUE, SETUP, CLOCK, GAP, FINISH, FAIL.
- IDLE: on `start`, latch secIn/minIn/hourIn and go to CHECK. busy=1 from the next cycle.
- CHECK (1 cycle):
  - invalid if any nibble >9, sec/min >0x59, or hour >0x23;
  - invalid: go to FAIL with errCode=01 and no wrEn;
  - valid: stepIdx=0, go to ISSUE.
- Step table:
  - 0: 8E/00
  - 1: 80/{0,sec[6:0]} (CH=0)
  - 2: 82/{0,min[6:0]}
  - 3: 84/{00,hour[5:0]}
  - 4: 8E/80
- ISSUE (1 cycle): wrEn=1; wrAddr/wrData set from the table. They stay stable until the next ISSUE or IDLE. Go to SETUP.
- SETUP: sclk=0 for SETUP_CYC cycles, then CLOCK.
- CLOCK:
  - divider toggles sclk every SCLK_HALF cycles;
  - first edge is a rise SCLK_HALF cycles after entry;
  - rising edges are counted;
  - wrDone=1 forces sclk=0 in the same cycle the state leaves CLOCK, then GAP;
  - wrDone has priority over timeout in the same cycle;
  - edge count reaching TIMEOUT_EDGES with wrDone=0 goes to FAIL with errCode=10.
- GAP: sclk=0 for GAP_CYC cycles.
  - stepIdx<4: increment, go to ISSUE;
  - stepIdx=4: go to FINISH.
- FINISH (1 cycle): done=1, then IDLE.
- FAIL (1 cycle): err=1, sclk=0, then IDLE.
- IDLE clears busy and stepIdx; wrAddr/wrData return to 0.
- `start` while busy is ignored (not queued). `start` in the same cycle as FINISH/FAIL is ignored.
- wrDone outside CLOCK is ignored.
- sclk is low at all times outside CLOCK.

Decomposition:
- Shared package ds1302_pkg holds:
  - register address constants: ADDR_WP=8E, ADDR_SEC=80, ADDR_MIN=82, ADDR_HOUR=84;
  - WP data constants: WP_UNLOCK=00, WP_LOCK=80;
  - the FSM state enum;
  - errCode constants.
  The read-side block reuses this package.
- One sub-module, ds1302_sclk_div. Inputs: clk, rst, run, SCLK_HALF. Outputs: sclk, risePulse. The counter clears and sclk goes low whenever run=0.

Test Plan:
- Common setup: SCLK_HALF=1, SETUP_CYC=2, GAP_CYC=2, TIMEOUT_EDGES=40. The bench model asserts wrDone 1 cycle after the 16th SCLK rise following wrEn.
- Normal: start with sec=0x45, min=0x30, hour=0x13 -> exactly five wrEn pulses with addr/data 8E/00, 80/45, 82/30, 84/13, 8E/80 in order; each write gets exactly 16 sclk rises; one done pulse; err=0; busy falls the cycle after done.
- Bad BCD: hour=0x24 (then sec=0x5A) -> err pulse with errCode=01 two cycles after start; no wrEn, sclk stays 0; busy low afterwards.
- Timeout: model never asserts wrDone at step 2 -> exactly 40 sclk rises in that step, then err with errCode=10; sclk=0; stepIdx returns to 0; no done.
- Restart ignored: start pulsed again during step 1 -> sequence unchanged; exactly one done.
- Reset mid-CLOCK: rst asserted while sclk=1 in step 3 -> sclk, wrEn, busy and stepIdx are 0 immediately; no done or err. A new start then completes normally.
- Simultaneous wrDone and 40th edge -> treated as success; the sequence continues to the next step.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared DS1302 definitions: register addresses, write-protect values, sequencer states, error codes.
// The read-side sequencer imports this package as well.
package ds1302_pkg;

    localparam logic [7:0] ADDR_WP   = 8'h8E;
    localparam logic [7:0] ADDR_SEC  = 8'h80;
    localparam logic [7:0] ADDR_MIN  = 8'h82;
    localparam logic [7:0] ADDR_HOUR = 8'h84;

    localparam logic [7:0] WP_UNLOCK = 8'h00;
    localparam logic [7:0] WP_LOCK   = 8'h80;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BCD     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [2:0] LAST_STEP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_SETUP,
        ST_CLOCK,
        ST_GAP,
        ST_FINISH,
        ST_FAIL
    } seq_state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_cmd_t;

    // Both nibbles are decimal digits and the value does not exceed max_v.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
    endfunction

endpackage

// File: rtl/ds1302_sclk_div.sv
// SCLK generator: toggles every SCLK_HALF clk cycles while run is high, first edge is a rise.
// Dropping run clears the divider and forces SCLK low on the next clk edge.
module ds1302_sclk_div #(
    parameter int unsigned SCLK_HALF = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic risePulse
);

    localparam int unsigned DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;
    logic             r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
            r_rise <= 1'b0;
        end else if (!run) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
            r_rise <= 1'b0;
        end else if (r_cnt == DIV_LAST) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_rise <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            r_rise <= 1'b0;
        end
    end

    assign sclk      = r_sclk;
    assign risePulse = r_rise;

endmodule

// File: rtl/ds1302_write_seq.sv
// Programs DS1302 seconds/minutes/hours through the ds1302write engine as five framed writes
// (WP unlock, sec, min, hour, WP lock), with input validation and a per-write SCLK-edge timeout.
module ds1302_write_seq
    import ds1302_pkg::*;
#(
    parameter int unsigned SCLK_HALF     = 50,
    parameter int unsigned SETUP_CYC     = 400,
    parameter int unsigned GAP_CYC       = 400,
    parameter int unsigned TIMEOUT_EDGES = 40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] secIn,
    input  logic [7:0] minIn,
    input  logic [7:0] hourIn,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] errCode,
    output logic [2:0] stepIdx,
    output logic       wrEn,
    output logic [7:0] wrAddr,
    output logic [7:0] wrData,
    output logic       sclk,
    input  logic       wrDone
);

    localparam int unsigned CNT_MAX = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned EDGE_W  = $clog2(TIMEOUT_EDGES + 1);

    seq_state_t        r_state, w_state_next;
    logic [7:0]        r_sec, r_min, r_hour, w_sec_next, w_min_next, w_hour_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [EDGE_W-1:0] r_edge, w_edge_next;
    logic [2:0]        r_step, w_step_next;
    logic [1:0]        r_err_code, w_err_code_next;
    wr_cmd_t           r_cmd, w_cmd_next;
    logic              r_busy, r_done, r_err, r_wr_en;
    logic              w_busy_next, w_done_next, w_err_next, w_wr_en_next;
    logic              w_valid, w_run_c, w_sclk, w_rise;

    // Table of the five writes, indexed by step.
    function automatic wr_cmd_t step_cmd(input logic [2:0] idx, input logic [7:0] sec,
                                         input logic [7:0] min, input logic [7:0] hour);
        wr_cmd_t c;
        case (idx)
            3'd0:    begin c.addr = ADDR_WP;   c.data = WP_UNLOCK;     end
            3'd1:    begin c.addr = ADDR_SEC;  c.data = sec & 8'h7F;   end
            3'd2:    begin c.addr = ADDR_MIN;  c.data = min & 8'h7F;   end
            3'd3:    begin c.addr = ADDR_HOUR; c.data = hour & 8'h3F;  end
            default: begin c.addr = ADDR_WP;   c.data = WP_LOCK;       end
        endcase
        return c;
    endfunction

    assign w_valid = bcd_in_range(r_sec, 8'h59) && bcd_in_range(r_min, 8'h59)
                  && bcd_in_range(r_hour, 8'h23);

    always_comb begin
        w_state_next    = r_state;
        w_sec_next      = r_sec;
        w_min_next      = r_min;
        w_hour_next     = r_hour;
        w_cnt_next      = r_cnt;
        w_step_next     = r_step;
        w_err_code_next = r_err_code;
        w_cmd_next      = r_cmd;
        w_edge_next     = (r_state == ST_CLOCK) ? r_edge + EDGE_W'(w_rise) : '0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_sec_next   = secIn;
                    w_min_next   = minIn;
                    w_hour_next  = hourIn;
                    w_state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_valid) begin
                    w_err_code_next = ERR_BCD;
                    w_state_next    = ST_FAIL;
                end else begin
                    w_step_next  = 3'd0;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_next   = '0;
                w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_CLOCK;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_CLOCK: begin
                // A done seen together with the final allowed edge still counts as success.
                if (wrDone) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_GAP;
                end else if (r_edge == EDGE_W'(TIMEOUT_EDGES)) begin
                    w_err_code_next = ERR_TIMEOUT;
                    w_state_next    = ST_FAIL;
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYC - 1)) begin
                    w_cnt_next = '0;
                    if (r_step == LAST_STEP) begin
                        w_state_next = ST_FINISH;
                    end else begin
                        w_step_next  = r_step + 3'd1;
                        w_state_next = ST_ISSUE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
            ST_FAIL:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase

        if (w_state_next == ST_ISSUE) begin
            w_cmd_next = step_cmd(w_step_next, r_sec, r_min, r_hour);
        end
        if (w_state_next == ST_IDLE) begin
            w_cmd_next  = '0;
            w_step_next = 3'd0;
        end

        w_busy_next  = (w_state_next != ST_IDLE);
        w_done_next  = (w_state_next == ST_FINISH);
        w_err_next   = (w_state_next == ST_FAIL);
        w_wr_en_next = (w_state_next == ST_ISSUE);
        // Stop the divider on the very edge that leaves CLOCK so SCLK is low in the next state.
        w_run_c      = (r_state == ST_CLOCK) && (w_state_next == ST_CLOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sec      <= '0;
            r_min      <= '0;
            r_hour     <= '0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_step     <= '0;
            r_err_code <= ERR_NONE;
            r_cmd      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_wr_en    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sec      <= w_sec_next;
            r_min      <= w_min_next;
            r_hour     <= w_hour_next;
            r_cnt      <= w_cnt_next;
            r_edge     <= w_edge_next;
            r_step     <= w_step_next;
            r_err_code <= w_err_code_next;
            r_cmd      <= w_cmd_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_err      <= w_err_next;
            r_wr_en    <= w_wr_en_next;
        end
    end

    ds1302_sclk_div #(
        .SCLK_HALF(SCLK_HALF)
    ) u_sclk_div (
        .clk      (clk),
        .rst      (rst),
        .run      (w_run_c),
        .sclk     (w_sclk),
        .risePulse(w_rise)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign errCode = r_err_code;
    assign stepIdx = r_step;
    assign wrEn    = r_wr_en;
    assign wrAddr  = r_cmd.addr;
    assign wrData  = r_cmd.data;
    assign sclk    = w_sclk;

endmodule
